// File: rtl/mux_pipeline_if.sv
// Beat-in / beat-out bundle for mux_pipeline. The slave modport is the mux side; the master
// modport is the producer/consumer side.
interface mux_pipeline_if #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned INPUT_COUNT = 2
);
  localparam int unsigned SEL_W = $clog2(INPUT_COUNT);

  logic                         i_valid;
  logic [SEL_W-1:0]             i_sel;
  logic [WIDTH*INPUT_COUNT-1:0] i_data;
  logic                         o_valid;
  logic [SEL_W-1:0]             o_sel;
  logic [WIDTH-1:0]             o_data;

  modport master (
    output i_valid, i_sel, i_data,
    input  o_valid, o_sel, o_data
  );

  modport slave (
    input  i_valid, i_sel, i_data,
    output o_valid, o_sel, o_data
  );
endinterface

// File: rtl/mux_pipeline.sv
// N:1 gather mux built as a radix-R tree with one register rank per level, followed by plain
// delay stages so the total latency is exactly LATENCY. LATENCY=0 is a purely combinational mux.
module mux_pipeline #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned INPUT_COUNT = 2,
  parameter int unsigned LATENCY     = 1
) (
  input logic            clk,
  input logic            rst,
  mux_pipeline_if.slave  io_bus
);
  localparam int unsigned SEL_W  = $clog2(INPUT_COUNT);
  localparam int unsigned LAT_D  = (LATENCY == 0) ? 1 : LATENCY;
  localparam int unsigned B      = (SEL_W + LAT_D - 1) / LAT_D;
  localparam int unsigned R      = 1 << B;
  localparam int unsigned LEVELS = (SEL_W + B - 1) / B;
  localparam int unsigned PAD    = (LATENCY > LEVELS) ? LATENCY - LEVELS : 0;

  // Lanes still alive at the input of tree level k.
  function automatic int unsigned lanes_in(int unsigned k);
    int unsigned n;
    n = INPUT_COUNT;
    for (int unsigned i = 0; i < k; i++) n = (n + R - 1) / R;
    return n;
  endfunction

  if (LATENCY == 0) begin : g_comb
    logic [(1 << SEL_W)*WIDTH-1:0] w_pad;

    always_comb begin
      w_pad = '0;
      w_pad[INPUT_COUNT*WIDTH-1:0] = io_bus.i_data;
    end

    assign io_bus.o_data  = w_pad[32'(io_bus.i_sel) * WIDTH +: WIDTH];
    assign io_bus.o_valid = io_bus.i_valid;
    assign io_bus.o_sel   = io_bus.i_sel;
  end else begin : g_pipe
    logic [LATENCY-1:0] r_valid;
    logic [SEL_W-1:0]   r_sel [LATENCY];
    logic [WIDTH-1:0]   w_tree;

    // Full sel rides alongside the data; each level slices its own bits out of it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= '0;
        for (int s = 0; s < LATENCY; s++) r_sel[s] <= '0;
      end else begin
        r_valid[0] <= io_bus.i_valid;
        r_sel[0]   <= io_bus.i_valid ? io_bus.i_sel : '0;
        for (int s = 1; s < LATENCY; s++) begin
          r_valid[s] <= r_valid[s-1];
          r_sel[s]   <= r_sel[s-1];
        end
      end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int unsigned NIN  = lanes_in(k);
      localparam int unsigned NOUT = lanes_in(k + 1);

      logic [NIN*WIDTH-1:0]    w_src;
      logic [SEL_W-1:0]        w_sel;
      logic [B-1:0]            w_slice;
      logic [NOUT*R*WIDTH-1:0] w_pad;
      logic [NOUT*WIDTH-1:0]   w_red;
      logic [NOUT*WIDTH-1:0]   r_data;

      if (k == 0) begin : g_src
        assign w_src = io_bus.i_valid ? io_bus.i_data : '0;
        assign w_sel = io_bus.i_sel;
      end else begin : g_src
        assign w_src = g_lvl[k-1].r_data;
        assign w_sel = r_sel[k-1];
      end

      assign w_slice = B'(w_sel >> (k * B));

      // Missing group members read as the zero padding above the live lanes.
      always_comb begin
        w_pad = '0;
        w_pad[NIN*WIDTH-1:0] = w_src;
        w_red = '0;
        for (int unsigned g = 0; g < NOUT; g++) begin
          w_red[g*WIDTH +: WIDTH] = w_pad[(g*R + 32'(w_slice))*WIDTH +: WIDTH];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_data <= '0;
        else     r_data <= w_red;
      end
    end

    assign w_tree = g_lvl[LEVELS-1].r_data;

    if (PAD > 0) begin : g_pad
      logic [WIDTH-1:0] r_pad [PAD];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int p = 0; p < PAD; p++) r_pad[p] <= '0;
        end else begin
          r_pad[0] <= w_tree;
          for (int p = 1; p < PAD; p++) r_pad[p] <= r_pad[p-1];
        end
      end

      assign io_bus.o_data = r_pad[PAD-1];
    end else begin : g_nopad
      assign io_bus.o_data = w_tree;
    end

    assign io_bus.o_valid = r_valid[LATENCY-1];
    assign io_bus.o_sel   = r_sel[LATENCY-1];
  end
endmodule
